// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP unit-propagation scan block.
package bcp_pkg;

  localparam int UNIT_CNT_W = 16;

  typedef enum logic [1:0] {
    UNASSIGNED = 2'b00,
    TRUE       = 2'b01,
    FALSE      = 2'b10,
    RSVD       = 2'b11
  } lit_state_e;

  typedef enum logic [1:0] {
    SAT,
    UNIT,
    CONFL,
    OPEN
  } clause_class_e;

endpackage

// File: rtl/bcp_impl_fifo.sv
// Implication queue: power-of-two depth circular buffer with flush.
module bcp_impl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a push into a full queue is fine when the head leaves on the same edge
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RST_N || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bcp_unit_scan.sv
// Clause scanner: one registered classify stage feeding an implication queue
// and a sticky conflict flag.
module bcp_unit_scan
  import bcp_pkg::*;
#(
  parameter int NUM_LIT = 4,
  parameter int CID_W   = 8,
  parameter int QDEPTH  = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CLAUSE_VALID,
  output logic                        CLAUSE_READY,
  input  logic [CID_W-1:0]            CLAUSE_ID,
  input  logic [2*NUM_LIT-1:0]        LIT_STATE,
  output logic                        IMPL_VALID,
  input  logic                        IMPL_READY,
  output logic [CID_W-1:0]            IMPL_CID,
  output logic [$clog2(NUM_LIT)-1:0]  IMPL_IDX,
  output logic                        CONFLICT,
  output logic [CID_W-1:0]            CONFLICT_CID,
  input  logic                        CLR_CONFLICT,
  output logic [UNIT_CNT_W-1:0]       UNIT_CNT
);
  localparam int IDX_W  = $clog2(NUM_LIT);
  localparam int NU_W   = $clog2(NUM_LIT + 1);
  localparam int ENT_W  = CID_W + IDX_W;
  localparam int QCNT_W = $clog2(QDEPTH) + 1;
  localparam logic [QCNT_W:0] QD_L = QDEPTH;

  logic                   stg_vld;
  logic [CID_W-1:0]       stg_cid;
  logic [2*NUM_LIT-1:0]   stg_lits;
  logic [NUM_LIT-1:0]     lit_t, lit_u;
  logic [NU_W-1:0]        n_unasg;
  logic [IDX_W-1:0]       unit_idx;
  clause_class_e          cls;
  logic                   accept, push, pop, q_empty;
  logic [QCNT_W-1:0]      q_cnt;
  logic [QCNT_W:0]        occ;
  logic [ENT_W-1:0]       q_head;
  logic                   conflict_q;
  logic [CID_W-1:0]       conflict_cid_q;
  logic [UNIT_CNT_W-1:0]  unit_cnt_q;

  // reserved code 11 decodes as neither true nor unassigned, i.e. false
  for (genvar i = 0; i < NUM_LIT; i++) begin : g_lit
    assign lit_t[i] = (lit_state_e'(stg_lits[2*i +: 2]) == TRUE);
    assign lit_u[i] = (lit_state_e'(stg_lits[2*i +: 2]) == UNASSIGNED);
  end

  always_comb begin
    n_unasg  = '0;
    unit_idx = '0;
    cls      = OPEN;
    for (int i = 0; i < NUM_LIT; i++) begin
      if (lit_u[i]) begin
        n_unasg  = n_unasg + 1'b1;
        unit_idx = IDX_W'(i);
      end
    end
    if (|lit_t)                      cls = SAT;
    else if (n_unasg == NU_W'(1))    cls = UNIT;
    else if (n_unasg == '0)          cls = CONFL;
  end

  // the in-flight clause counts as occupancy so its push always has room
  assign occ          = {1'b0, q_cnt} + {{QCNT_W{1'b0}}, stg_vld};
  assign CLAUSE_READY = RST_N & ~conflict_q & ~CLR_CONFLICT & (occ < QD_L);
  assign accept       = CLAUSE_VALID & CLAUSE_READY;
  assign push         = stg_vld & (cls == UNIT) & ~conflict_q & ~CLR_CONFLICT;
  assign IMPL_VALID   = RST_N & ~q_empty;
  assign pop          = IMPL_VALID & IMPL_READY;

  bcp_impl_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (CLR_CONFLICT),
    .push  (push),
    .wdata ({stg_cid, unit_idx}),
    .pop   (pop),
    .rdata (q_head),
    .empty (q_empty),
    .count (q_cnt)
  );

  assign {IMPL_CID, IMPL_IDX} = q_head;
  assign CONFLICT             = conflict_q;
  assign CONFLICT_CID         = conflict_cid_q;
  assign UNIT_CNT             = unit_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR_CONFLICT) stg_vld <= 1'b0;
    else                        stg_vld <= accept;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      stg_cid  <= CLAUSE_ID;
      stg_lits <= LIT_STATE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR_CONFLICT) begin
      conflict_q     <= 1'b0;
      conflict_cid_q <= '0;
    end else if (stg_vld && cls == CONFL && !conflict_q) begin
      conflict_q     <= 1'b1;
      conflict_cid_q <= stg_cid;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)                          unit_cnt_q <= '0;
    else if (push && unit_cnt_q != '1)   unit_cnt_q <= unit_cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_bcp_unit_scan.sv
// Directed bench for bcp_unit_scan with a queue-based reference model.
module tb_bcp_unit_scan;
  localparam int NL = 4, CW = 8, QD = 8, IW = 2;

  logic          CLK = 1'b0, RST_N = 1'b0;
  logic          CLAUSE_VALID = 1'b0, CLAUSE_READY;
  logic [CW-1:0] CLAUSE_ID = '0;
  logic [2*NL-1:0] LIT_STATE = '0;
  logic          IMPL_VALID, IMPL_READY = 1'b0;
  logic [CW-1:0] IMPL_CID, CONFLICT_CID;
  logic [IW-1:0] IMPL_IDX;
  logic          CONFLICT, CLR_CONFLICT = 1'b0;
  logic [15:0]   UNIT_CNT;

  int n_chk = 0, n_pass = 0;
  bit started = 1'b0;
  logic [CW-1:0] obs[$];

  always #5 CLK = ~CLK;

  bcp_unit_scan #(.NUM_LIT(NL), .CID_W(CW), .QDEPTH(QD)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLAUSE_VALID(CLAUSE_VALID), .CLAUSE_READY(CLAUSE_READY),
    .CLAUSE_ID(CLAUSE_ID), .LIT_STATE(LIT_STATE), .IMPL_VALID(IMPL_VALID),
    .IMPL_READY(IMPL_READY), .IMPL_CID(IMPL_CID), .IMPL_IDX(IMPL_IDX),
    .CONFLICT(CONFLICT), .CONFLICT_CID(CONFLICT_CID), .CLR_CONFLICT(CLR_CONFLICT),
    .UNIT_CNT(UNIT_CNT)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [CW-1:0] cid; logic [IW-1:0] idx; } impl_t;
  impl_t         m_q[$];
  bit            m_conf, m_inf, m_acc, m_pop;
  logic [CW-1:0] m_ccid, m_icid;
  logic [2*NL-1:0] m_ilit;
  int            m_cnt, m_cls, m_idx;

  // 0 SAT, 1 UNIT, 2 CONFL, 3 OPEN
  function automatic void classify(input logic [2*NL-1:0] l, output int c, output int idx);
    int nu = 0;
    bit t = 0;
    idx = 0;
    for (int i = 0; i < NL; i++) begin
      if (l[2*i +: 2] == 2'b01) t = 1;
      else if (l[2*i +: 2] == 2'b00) begin nu++; idx = i; end
    end
    c = t ? 0 : (nu == 1) ? 1 : (nu == 0) ? 2 : 3;
  endfunction

  function automatic bit m_ready();
    return RST_N && !m_conf && !CLR_CONFLICT && (m_q.size() + int'(m_inf) < QD);
  endfunction

  always @(posedge CLK) begin
    m_acc = CLAUSE_VALID && m_ready();
    m_pop = RST_N && m_q.size() > 0 && IMPL_READY;
    if (!RST_N) begin
      m_q.delete(); m_conf = 0; m_ccid = '0; m_cnt = 0; m_inf = 0;
    end else if (CLR_CONFLICT) begin
      m_q.delete(); m_conf = 0; m_ccid = '0; m_inf = 0;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_inf && !m_conf) begin
        classify(m_ilit, m_cls, m_idx);
        if (m_cls == 1) begin
          m_q.push_back('{cid: m_icid, idx: IW'(m_idx)});
          if (m_cnt < 65535) m_cnt++;
        end else if (m_cls == 2) begin
          m_conf = 1; m_ccid = m_icid;
        end
      end
      m_inf = m_acc;
      if (m_acc) begin m_icid = CLAUSE_ID; m_ilit = LIT_STATE; end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("ready", CLAUSE_READY, m_ready());
      chk("impl_valid", IMPL_VALID, RST_N && m_q.size() > 0);
      if (RST_N && m_q.size() > 0) begin
        chk("impl_cid", IMPL_CID, m_q[0].cid);
        chk("impl_idx", IMPL_IDX, m_q[0].idx);
      end
      chk("conflict", CONFLICT, m_conf);
      chk("conflict_cid", CONFLICT_CID, m_ccid);
      chk("unit_cnt", UNIT_CNT, m_cnt);
      if (IMPL_VALID && IMPL_READY) obs.push_back(IMPL_CID);
    end
  end

  // ---------------- stimulus ----------------
  // called #1 after a rising edge; returns #1 after the accepting edge
  task automatic send(input logic [CW-1:0] id, input logic [2*NL-1:0] l);
    int b = 0;
    CLAUSE_VALID = 1'b1; CLAUSE_ID = id; LIT_STATE = l;
    @(negedge CLK);
    while (!CLAUSE_READY && b < 40) begin b++; @(negedge CLK); end
    if (!CLAUSE_READY) begin
      n_chk++;
      $display("FAIL send_timeout id=%0d: ready %b want 1", id, CLAUSE_READY);
    end
    @(posedge CLK); #1;
    CLAUSE_VALID = 1'b0;
  endtask

  function automatic logic [2*NL-1:0] unit_lits(input int k);
    logic [2*NL-1:0] l;
    l = 8'hAA;
    l[2*(k % NL) +: 2] = 2'b00;
    return l;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    tick(); started = 1'b1;
    @(negedge CLK);
    chk("rst_ready", CLAUSE_READY, 0);
    chk("rst_impl_valid", IMPL_VALID, 0);
    tick(); RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", CLAUSE_READY, 1);
    chk("post_rst_cnt", UNIT_CNT, 0);
    chk("post_rst_conflict", CONFLICT, 0);

    // single unit clause, index 1
    tick();
    send(8'd5, 8'b10_10_00_10);
    @(negedge CLK); chk("unit_not_yet", IMPL_VALID, 0);
    @(negedge CLK);
    chk("unit_valid", IMPL_VALID, 1);
    chk("unit_cid", IMPL_CID, 5);
    chk("unit_idx", IMPL_IDX, 1);
    chk("unit_cnt1", UNIT_CNT, 1);
    tick(); IMPL_READY = 1'b1;
    tick(); IMPL_READY = 1'b0;
    @(negedge CLK); chk("unit_popped", IMPL_VALID, 0);

    // SAT then OPEN: no effect
    tick();
    send(8'd6, 8'b01_00_00_10);
    send(8'd7, 8'b00_00_10_10);
    repeat (3) @(negedge CLK);
    chk("sat_open_valid", IMPL_VALID, 0);
    chk("sat_open_cnt", UNIT_CNT, 1);

    // queued unit, then two conflicts back-to-back; first ID sticks
    tick();
    send(8'd20, 8'b00_10_10_10);
    send(8'd9,  8'b10_11_10_10);
    send(8'd11, 8'b10_11_10_10);
    @(negedge CLK);
    chk("confl_set", CONFLICT, 1);
    chk("confl_cid", CONFLICT_CID, 9);
    chk("confl_ready", CLAUSE_READY, 0);
    @(negedge CLK); chk("confl_cid_sticky", CONFLICT_CID, 9);
    tick(); CLR_CONFLICT = 1'b1;
    @(negedge CLK); chk("clr_ready_low", CLAUSE_READY, 0);
    tick(); CLR_CONFLICT = 1'b0;
    @(negedge CLK);
    chk("clr_conflict", CONFLICT, 0);
    chk("clr_cid", CONFLICT_CID, 0);
    chk("clr_flush", IMPL_VALID, 0);
    chk("clr_ready", CLAUSE_READY, 1);
    chk("clr_cnt_kept", UNIT_CNT, 2);

    // conflict result in the same cycle as clear: clear wins
    tick();
    send(8'd12, 8'b10_11_10_10);
    CLR_CONFLICT = 1'b1;
    tick(); CLR_CONFLICT = 1'b0;
    @(negedge CLK); chk("clr_wins", CONFLICT, 0);

    // fill to depth with consumer stalled, then drain in order
    tick();
    obs.delete();
    for (int k = 0; k < 8; k++) send(CW'(100 + k), unit_lits(k));
    CLAUSE_VALID = 1'b1; CLAUSE_ID = 8'd108; LIT_STATE = unit_lits(8);
    repeat (4) @(negedge CLK);
    chk("full_ready_low", CLAUSE_READY, 0);
    chk("full_no_pops", obs.size(), 0);
    tick(); IMPL_READY = 1'b1;
    send(8'd108, unit_lits(8));
    send(8'd109, unit_lits(9));
    repeat (20) @(negedge CLK);
    chk("drain_count", obs.size(), 10);
    for (int k = 0; k < 10 && k < obs.size(); k++) chk($sformatf("drain_order%0d", k), obs[k], 100 + k);
    chk("drain_cnt", UNIT_CNT, 12);

    // streaming through several pointer wraps
    tick();
    obs.delete();
    for (int k = 0; k < 20; k++) send(CW'(200 + k), unit_lits(k));
    repeat (6) @(negedge CLK);
    chk("stream_count", obs.size(), 20);
    if (obs.size() == 20) chk("stream_last", obs[19], 219);
    chk("stream_cnt", UNIT_CNT, 32);

    // reset mid-operation with 3 queued and one in flight
    tick(); IMPL_READY = 1'b0;
    for (int k = 0; k < 4; k++) send(CW'(50 + k), unit_lits(k));
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_ready", CLAUSE_READY, 0);
    chk("midrst_valid", IMPL_VALID, 0);
    tick(); RST_N = 1'b1;
    @(negedge CLK);
    chk("after_rst_valid", IMPL_VALID, 0);
    chk("after_rst_cnt", UNIT_CNT, 0);
    chk("after_rst_ready", CLAUSE_READY, 1);
    tick(); IMPL_READY = 1'b1; obs.delete();
    repeat (5) @(negedge CLK);
    chk("no_stale", obs.size(), 0);
    tick();
    send(8'd77, unit_lits(3));
    repeat (3) @(negedge CLK);
    chk("resume_pop", obs.size(), 1);
    if (obs.size() == 1) chk("resume_cid", obs[0], 77);
    chk("resume_cnt", UNIT_CNT, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
